// File: rtl/mem_fill_pkg.sv
// Shared types for the memory fill/check engine.
//   mode_e  : operation selected at start
//   state_e : engine FSM states
package mem_fill_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    FILL_IDENT  = 2'b00,
    FILL_CONST  = 2'b01,
    FILL_RAMP   = 2'b10,
    CHECK_IDENT = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/mem_fill_datagen.sv
// Pattern generator for the fill engine.
//   mode_i    : latched operation mode
//   addr_i    : current memory address (identity source)
//   seed_i    : constant / ramp seed, captured on load_i
//   step_i    : ramp increment, captured on load_i
//   load_i    : capture seed/step (run start)
//   advance_i : step the ramp accumulator (one written word)
//   data_o    : pattern word for the current address
// The identity value is also the expected read data in check mode.
module mem_fill_datagen
  import mem_fill_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  mode_e                 mode_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  input  logic [DATA_WIDTH-1:0] step_i,
  input  logic                  load_i,
  input  logic                  advance_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;
  logic [DATA_WIDTH-1:0] ident;

  // Address resized to the data width: zero-extend or truncate.
  generate
    if (DATA_WIDTH > ADDR_WIDTH) begin : g_zext
      assign ident = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, addr_i};
    end else begin : g_trunc
      assign ident = addr_i[DATA_WIDTH-1:0];
    end
  endgenerate

  // Accumulator holds the constant in CONST mode and seed+k*step in RAMP mode.
  always_comb begin
    acc_d  = acc_q;
    step_d = step_q;
    if (load_i) begin
      acc_d  = seed_i;
      step_d = step_i;
    end else if (advance_i && mode_i == FILL_RAMP) begin
      acc_d = acc_q + step_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      step_q <= '0;
    end else begin
      acc_q  <= acc_d;
      step_q <= step_d;
    end
  end

  always_comb begin
    case (mode_i)
      FILL_IDENT, CHECK_IDENT: data_o = ident;
      default:                 data_o = acc_q;
    endcase
  end

endmodule

// File: rtl/mem_fill_engine.sv
// On-chip RAM initialiser / identity checker.
//   clk, rst            : clock, async active-high reset
//   start               : run request (accepted in IDLE or DONE)
//   mode                : 00 ident fill, 01 const fill, 10 ramp fill, 11 ident check
//   base_addr/last_addr : inclusive address window
//   fill_value, step    : constant or ramp seed, ramp increment
//   address/data/wren   : single-port RAM write/read port
//   q                   : RAM read data, MEM_LATENCY cycles after address
//   busy, finish        : run in progress / run complete (level)
//   error, err_addr     : first identity mismatch in check mode
module mem_fill_engine
  import mem_fill_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [MODE_W-1:0]     mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  input  logic [DATA_WIDTH-1:0] fill_value,
  input  logic [DATA_WIDTH-1:0] step,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  wren,
  input  logic [DATA_WIDTH-1:0] q,
  output logic                  busy,
  output logic                  finish,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                  accept, advance;
  logic [DATA_WIDTH-1:0] gen_data;

  mem_fill_datagen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_gen (
    .clk      (clk),
    .rst      (rst),
    .mode_i   (mode_q),
    .addr_i   (addr_q),
    .seed_i   (fill_value),
    .step_i   (step),
    .load_i   (accept),
    .advance_i(advance),
    .data_o   (gen_data)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    last_d     = last_q;
    lat_d      = lat_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    accept     = 1'b0;
    advance    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          mode_d     = mode_e'(mode);
          last_d     = last_addr;
          addr_d     = base_addr;
          err_d      = 1'b0;
          err_addr_d = '0;
          if (base_addr > last_addr)            state_d = DONE;
          else if (mode_e'(mode) == CHECK_IDENT) state_d = RD_ADDR;
          else                                  state_d = WRITE;
        end
      end
      WRITE: begin
        advance = 1'b1;
        // Compare before incrementing so a window ending at the top address never wraps.
        if (addr_q == last_q) state_d = DONE;
        else                  addr_d  = addr_q + 1'b1;
      end
      RD_ADDR: begin
        lat_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_q == LAT_W'(MEM_LATENCY-1)) begin
          if (q != gen_data) begin
            err_d      = 1'b1;
            err_addr_d = addr_q;
            state_d    = DONE;
          end else if (addr_q == last_q) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = RD_ADDR;
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= FILL_IDENT;
      addr_q     <= '0;
      last_q     <= '0;
      lat_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      lat_q      <= lat_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Decoded from the state register so reset drops wren/busy/finish asynchronously.
  assign wren     = (state_q == WRITE);
  assign data     = wren ? gen_data : '0;
  assign busy     = (state_q == WRITE) || (state_q == RD_ADDR) || (state_q == RD_WAIT);
  assign finish   = (state_q == DONE);
  assign address  = addr_q;
  assign error    = err_q;
  assign err_addr = err_addr_q;

endmodule
